// File: rtl/axis_modport.sv
// AXI-Stream register slice: two-entry skid buffer that registers both the forward path and tready.
// Optional beat/packet counters are built when AXIS_MODPORT_STATS_EN is defined.
module axis_modport #(
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser
`ifdef AXIS_MODPORT_STATS_EN
    ,
    output logic [31:0]           beat_count,
    output logic [31:0]           pkt_count
`endif
);

    localparam int PW = DATA_WIDTH + 1 + USER_WIDTH;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   out_q, out_d;
    logic [PW-1:0]   skid_q, skid_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic [PW-1:0]   in_payload_s;
    logic            up_s;
    logic            dn_s;

    assign in_payload_s = {s_axis_tdata, s_axis_tlast, s_axis_tuser};
    assign up_s         = s_axis_tvalid & ready_q;
    assign dn_s         = valid_q & m_axis_tready;

    // State and storage registers; tready/tvalid are registered copies of the next state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (up_s) state_d = ST_BUSY;
                else      state_d = ST_EMPTY;
            end
            ST_BUSY: begin
                if (up_s && !dn_s)      state_d = ST_FULL;
                else if (!up_s && dn_s) state_d = ST_EMPTY;
                else                    state_d = ST_BUSY;
            end
            ST_FULL: begin
                if (dn_s) state_d = ST_BUSY;
                else      state_d = ST_FULL;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Datapath steering and registered handshake values derived from the next state.
    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (up_s) out_d = in_payload_s;
                else      out_d = out_q;
            end
            ST_BUSY: begin
                if (up_s && dn_s) out_d  = in_payload_s;
                else if (up_s)    skid_d = in_payload_s;
                else              out_d  = out_q;
            end
            ST_FULL: begin
                if (dn_s) out_d = skid_q;
                else      out_d = out_q;
            end
            default: begin
                out_d  = '0;
                skid_d = '0;
            end
        endcase
        ready_d = (state_d != ST_FULL);
        valid_d = (state_d != ST_EMPTY);
    end

    assign s_axis_tready = ready_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tdata  = out_q[PW-1 -: DATA_WIDTH];
    assign m_axis_tlast  = out_q[USER_WIDTH];
    assign m_axis_tuser  = out_q[USER_WIDTH-1:0];

`ifdef AXIS_MODPORT_STATS_EN
    logic [31:0] beat_cnt_q, beat_cnt_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;

    // Counters advance on downstream transfers and wrap naturally at 32 bits.
    always_comb begin
        if (dn_s) beat_cnt_d = beat_cnt_q + 32'd1;
        else      beat_cnt_d = beat_cnt_q;
        if (dn_s && out_q[USER_WIDTH]) pkt_cnt_d = pkt_cnt_q + 32'd1;
        else                           pkt_cnt_d = pkt_cnt_q;
    end

    // Counter registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt_q <= 32'd0;
            pkt_cnt_q  <= 32'd0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign beat_count = beat_cnt_q;
    assign pkt_count  = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axis_modport.sv
// Directed and random-backpressure bench for axis_modport (DATA_WIDTH=8, USER_WIDTH=4).
module tb_axis_modport;

    localparam int DW = 8;
    localparam int UW = 4;
    localparam int PW = DW + 1 + UW;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [UW-1:0] s_tuser;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [UW-1:0] m_tuser;
`ifdef AXIS_MODPORT_STATS_EN
    logic [31:0]   beat_count;
    logic [31:0]   pkt_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [PW-1:0] sb_q [$];
    logic [PW-1:0] exp_beat;
    logic [PW-1:0] snap;
    logic          pending;
    logic          stall_chk;
    logic          up;
    logic          dn;
    int            sent;
    int            cyc;

    always #5 aclk = ~aclk;

    axis_modport #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser)
`ifdef AXIS_MODPORT_STATS_EN
        ,
        .beat_count    (beat_count),
        .pkt_count     (pkt_count)
`endif
    );

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with upstream valid asserted
        aresetn  = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 8'h55;
        s_tlast  = 1'b1;
        s_tuser  = 4'hF;
        m_tready = 1'b1;
        tick;
        tick;
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_s_tready", s_tready, 1'b0);
        check("rst_m_tdata", m_tdata, 8'h00);
        check("rst_m_tlast", m_tlast, 1'b0);
        check("rst_m_tuser", m_tuser, 4'h0);
        aresetn = 1'b1;
        #1;
        check("rel_s_tready_before_edge", s_tready, 1'b0);
        tick;
        check("rel_s_tready_after_edge", s_tready, 1'b1);
        check("rel_m_tvalid_after_edge", m_tvalid, 1'b0);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 4'h0;

        // Back-to-back streaming 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            s_tdata  = i[7:0];
            s_tuser  = i[3:0];
            s_tlast  = (i == 15);
            s_tvalid = 1'b1;
            tick;
            check("stream_valid", m_tvalid, 1'b1);
            check("stream_data", m_tdata, i[7:0]);
            check("stream_last", m_tlast, (i == 15));
            check("stream_user", m_tuser, i[3:0]);
            check("stream_ready", s_tready, 1'b1);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        tick;
        check("stream_drain_valid", m_tvalid, 1'b0);

        // Downstream stall: two beats buffered, third held upstream
        m_tready = 1'b0;
        s_tuser  = 4'h0;
        s_tdata  = 8'hA1;
        s_tvalid = 1'b1;
        tick;
        check("stall_a1_out", m_tdata, 8'hA1);
        check("stall_a1_ready", s_tready, 1'b1);
        s_tdata = 8'hA2;
        tick;
        check("stall_full_ready", s_tready, 1'b0);
        check("stall_full_out", m_tdata, 8'hA1);
        s_tdata = 8'hA3;
        tick;
        tick;
        check("stall_hold_ready", s_tready, 1'b0);
        check("stall_hold_out", m_tdata, 8'hA1);
        check("stall_hold_valid", m_tvalid, 1'b1);
        m_tready = 1'b1;
        tick;
        check("stall_rel_a2", m_tdata, 8'hA2);
        check("stall_rel_ready", s_tready, 1'b1);
        tick;
        check("stall_rel_a3", m_tdata, 8'hA3);
        check("stall_rel_a3_valid", m_tvalid, 1'b1);
        s_tvalid = 1'b0;
        tick;
        check("stall_drain_valid", m_tvalid, 1'b0);

        // Reset while FULL
        m_tready = 1'b0;
        s_tdata  = 8'hB1;
        s_tvalid = 1'b1;
        tick;
        s_tdata = 8'hB2;
        tick;
        check("midrst_full_ready", s_tready, 1'b0);
        s_tvalid = 1'b0;
        aresetn  = 1'b0;
        #1;
        check("midrst_m_tvalid", m_tvalid, 1'b0);
        check("midrst_s_tready", s_tready, 1'b0);
        check("midrst_m_tdata", m_tdata, 8'h00);
        #3;
        aresetn = 1'b1;
        tick;
        check("midrst_rel_ready", s_tready, 1'b1);
        check("midrst_rel_valid", m_tvalid, 1'b0);
        s_tdata  = 8'hC1;
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        tick;
        check("midrst_first_valid", m_tvalid, 1'b1);
        check("midrst_first_data", m_tdata, 8'hC1);
        s_tvalid = 1'b0;
        tick;
        check("midrst_drain_valid", m_tvalid, 1'b0);

        // Random valid/ready with scoreboard and hold-stability checks
        pending = 1'b0;
        sent    = 0;
        cyc     = 0;
        while ((sent < 1000 || sb_q.size() != 0) && cyc < 20000) begin
            if (!pending) begin
                if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                    s_tvalid = 1'b1;
                    s_tdata  = 8'($urandom_range(0, 255));
                    s_tlast  = 1'($urandom_range(0, 1));
                    s_tuser  = 4'($urandom_range(0, 15));
                    pending  = 1'b1;
                end else begin
                    s_tvalid = 1'b0;
                end
            end
            m_tready  = ($urandom_range(0, 3) != 0);
            up        = s_tvalid & s_tready;
            dn        = m_tvalid & m_tready;
            stall_chk = m_tvalid & ~m_tready;
            snap      = {m_tdata, m_tlast, m_tuser};
            if (dn) begin
                check("rnd_sb_nonempty", (sb_q.size() != 0), 1'b1);
                if (sb_q.size() != 0) begin
                    exp_beat = sb_q.pop_front();
                    check("rnd_beat", {m_tdata, m_tlast, m_tuser}, exp_beat);
                end
            end
            tick;
            cyc++;
            if (stall_chk) begin
                check("rnd_hold_valid", m_tvalid, 1'b1);
                check("rnd_hold_payload", {m_tdata, m_tlast, m_tuser}, snap);
            end
            if (up) begin
                sb_q.push_back({s_tdata, s_tlast, s_tuser});
                sent++;
                pending = 1'b0;
            end
        end
        check("rnd_all_delivered", (sent == 1000 && sb_q.size() == 0), 1'b1);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        tick;
        tick;
        check("rnd_drain_valid", m_tvalid, 1'b0);

`ifdef AXIS_MODPORT_STATS_EN
        // Counters: 3 packets of 5 beats, then wrap
        aresetn = 1'b0;
        #2;
        aresetn = 1'b1;
        tick;
        check("stats_rst_beat", beat_count, 32'd0);
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 5; b++) begin
                s_tdata  = 8'(p * 16 + b);
                s_tlast  = (b == 4);
                s_tvalid = 1'b1;
                tick;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        tick;
        check("stats_beat_15", beat_count, 32'd15);
        check("stats_pkt_3", pkt_count, 32'd3);
        force dut.beat_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.beat_cnt_q;
        check("stats_forced", beat_count, 32'hFFFF_FFFF);
        s_tdata  = 8'h77;
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        tick;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        tick;
        check("stats_beat_wrap", beat_count, 32'd0);
        check("stats_pkt_4", pkt_count, 32'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
